instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Sequences the byte-addressed, 256-byte instruction memory: owns the PC, drives
//  the memory read_address, waits out the memory read latency, and buffers fetched
//  words in a small prefetch FIFO. Presents instructions to decode with a
//  valid/ready handshake. Accepts branch/jump redirects that flush all buffered
//  and in-flight fetches. Sits between instruction_memory and the decode stage.
// PARAMETERS
//  ADDR_WIDTH   8      byte-address width; must match instruction_memory
//  RESET_PC     8'h00  PC loaded on reset; low 2 bits must be 0
//  MEM_LATENCY  0      cycles from read_address change to valid instruction (0..7)
//  FIFO_DEPTH   2      prefetch entries (power of 2, 2..8)
// PORTS
//  clk             in   1          rising-edge clock
//  rst_n           in   1          async active-low reset
//  read_address    out  ADDR_WIDTH to instruction_memory; always a multiple of 4
//  instruction     in   32         from instruction_memory
//  redirect_valid  in   1          1-cycle pulse: restart fetch at redirect_pc
//  redirect_pc     in   ADDR_WIDTH new fetch byte address
//  inst_valid      out  1          FIFO head valid
//  inst_data       out  32         FIFO head instruction
//  inst_pc         out  ADDR_WIDTH byte address of inst_data
//  inst_ready      in   1          decode accepts head when inst_valid & inst_ready
//  misaligned_err  out  1          sticky: a redirect_pc had [1:0] != 0
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=read_address=RESET_PC, FIFO empty, inst_valid=0,
//   inst_data=0, inst_pc=0, misaligned_err=0, state=ISSUE, wait counter=0.
//  FSM: ISSUE -> (space avail) MEM_LATENCY==0 ? capture now, stay ISSUE : WAIT
//   ISSUE -> (no space) FULL;  WAIT -> count MEM_LATENCY cycles, capture, -> ISSUE
//   FULL -> ISSUE once a pop frees an entry. read_address held stable in WAIT/FULL.
//  "Space avail" = count < FIFO_DEPTH, or count == FIFO_DEPTH with pop this cycle.
//  Capture: push {instruction, pc} into FIFO, pc <= pc + 4 (mod 256: 0xFC -> 0x00).
//  Throughput: MEM_LATENCY=0 -> 1 word/cycle sustained; L>0 -> 1 word per L+1 cycles.
//  Latency: first inst_valid 1 cycle after capture edge (FIFO registered output).
//  Pop: on inst_valid & inst_ready; head advances next edge. Simultaneous push+pop
//   keeps count unchanged. inst_data/inst_pc hold value while inst_valid & !inst_ready.
//  Redirect (highest priority, overrides push/pop same cycle): FIFO flushed, any
//   in-flight WAIT aborted (counter cleared, no push), pc <= {redirect_pc[7:2],2'b00},
//   state <= ISSUE; inst_valid=0 the following cycle. If redirect_pc[1:0] != 0,
//   misaligned_err set and held until reset.
//  Back-to-back redirects: each cycle's redirect wins; only the last one fetches.
//  Reset mid-WAIT or with FIFO full: all state discarded, no spurious inst_valid.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs fetch_count[15:0] (words pushed) and
//   stall_count[15:0] (cycles in FULL); both reset to 0, saturate at 16'hFFFF,
//   not cleared by redirect.
//  Undefined: those ports and counters do not exist; behaviour otherwise identical.
// TESTING
//  1 Reset, L=0, inst_ready=1 -> inst_pc 0x00,0x04,0x08.. on consecutive cycles,
//    inst_data equals memory words at those addresses.
//  2 L=2, inst_ready=1 -> one new inst_valid word every 3 cycles; read_address
//    stable through each WAIT.
//  3 inst_ready=0 for 10 cycles, DEPTH=2 -> exactly 2 words buffered, FSM in FULL,
//    read_address=0x08; release -> 0x00,0x04,0x08 in order, none lost/duplicated.
//  4 redirect_valid with redirect_pc=0x40 during WAIT and FIFO non-empty -> next
//    cycle inst_valid=0; next delivered inst_pc=0x40; no stale word appears.
//  5 redirect_pc=0x42 -> misaligned_err=1 (sticky), fetch resumes at 0x40.
//  6 redirect to 0xF8, run -> inst_pc 0xF8,0xFC,0x00 (wrap); async rst_n pulse
//    mid-stream -> outputs reset immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: PC, memory read sequencing, prefetch FIFO, redirect flush.
// Optional perf counters (fetch_count_o, stall_count_o) when FETCH_PERF_CNT_EN is defined.
module instruction_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           MEM_LATENCY = 0,
  parameter int unsigned           FIFO_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] read_address_o,
  input  logic [31:0]           instruction_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  inst_valid_o,
  output logic [31:0]           inst_data_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  input  logic                  inst_ready_i,
  output logic                  misaligned_err_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]           fetch_count_o,
  output logic [15:0]           stall_count_o
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [2:0]  LAT_LAST = (MEM_LATENCY == 0) ? 3'd0 : 3'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_FULL} state_t;

  state_t                state_q, state_d;
  logic [2:0]            wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  err_q;

  logic [31:0]           data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] tag_q  [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]         count_q;

  logic pop, space, push;

  assign inst_valid_o     = (count_q != '0);
  assign inst_data_o      = data_q[rd_ptr_q];
  assign inst_pc_o        = tag_q[rd_ptr_q];
  assign read_address_o   = pc_q;
  assign misaligned_err_o = err_q;

  assign pop   = inst_valid_o & inst_ready_i;
  assign space = (count_q < CW'(FIFO_DEPTH)) | pop;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pc_d    = pc_q;
    push    = 1'b0;
    unique case (state_q)
      S_ISSUE: begin
        if (!space) begin
          state_d = S_FULL;
        end else if (MEM_LATENCY == 0) begin
          push = 1'b1;
        end else begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end
      end
      S_WAIT: begin
        // Space was reserved on entry; the FIFO cannot fill while waiting.
        if (wcnt_q == LAT_LAST) begin
          push    = 1'b1;
          wcnt_d  = '0;
          state_d = S_ISSUE;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      S_FULL: begin
        if (pop) state_d = S_ISSUE;
      end
      default: state_d = S_ISSUE;
    endcase
    if (push) pc_d = pc_q + ADDR_WIDTH'(4);
    if (redirect_valid_i) begin
      push    = 1'b0;
      state_d = S_ISSUE;
      wcnt_d  = '0;
      pc_d    = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_ISSUE;
      wcnt_q   <= '0;
      pc_q     <= RESET_PC;
      err_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      pc_q    <= pc_d;
      if (redirect_valid_i && (redirect_pc_i[1:0] != 2'b00)) err_q <= 1'b1;
      if (redirect_valid_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          data_q[wr_ptr_q] <= instruction_i;
          tag_q[wr_ptr_q]  <= pc_q;
          wr_ptr_q         <= wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        if (push && !pop)      count_q <= count_q + CW'(1);
        else if (!push && pop) count_q <= count_q - CW'(1);
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, stall_cnt_q;

  assign fetch_count_o = fetch_cnt_q;
  assign stall_count_o = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push && (fetch_cnt_q != '1))             fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if ((state_q == S_FULL) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end
`endif

endmodule
